// File: rtl/memory_game_core.sv
// Game-control core for the keypad memorisation game: show a sequence, collect digits, score rounds.
// Optional INPUT_TIMEOUT_EN macro adds an idle-input timer in INPUT that counts as a miss on expiry.
module memory_game_core #(
    parameter int DIGITS        = 4,
    parameter int TIMER_W       = 24,
    parameter int T_EASY        = 7000000,
    parameter int T_MEDIUM      = 5000000,
    parameter int T_HARD        = 3000000,
    parameter int LIVES         = 3,
    parameter int SCORE_W       = 14,
    parameter int SCORE_MAX     = 9999,
    parameter int INPUT_TIMEOUT = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_pulse,
    input  logic [3:0]            key_value,
    input  logic [4*DIGITS-1:0]   seq_in,
    output logic                  seq_req,
    output logic                  show_number,
    output logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            entry_count,
    output logic [SCORE_W-1:0]    score,
    output logic [2:0]            lives_left,
    output logic [1:0]            difficulty,
    output logic [1:0]            state,
    output logic                  round_ok,
    output logic                  round_fail
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_INPUT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLR   = 4'hE;
    localparam logic [3:0] KEY_START = 4'hF;

    state_t               state_q, state_d;
    logic [1:0]           difficulty_q, difficulty_d;
    logic [W-1:0]         target_q, target_d;
    logic [W-1:0]         entry_q, entry_d;
    logic [3:0]           entry_count_q, entry_count_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [2:0]           lives_left_q, lives_left_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 show_number_q, show_number_d;
    logic                 seq_req_q, seq_req_d;
    logic                 round_ok_q, round_ok_d;
    logic                 round_fail_q, round_fail_d;

    // Idle-timer handshake: the FSM requests reloads/ticks, the timer reports expiry.
    logic                 to_load;
    logic                 to_tick;
    logic                 timeout_hit;

    logic [3:0]           exp_digit;
    logic [W-1:0]         entry_shifted;
    logic                 key_is_digit;
    logic                 key_accepted;
    logic                 miss;

    function automatic logic [TIMER_W-1:0] show_time(input logic [1:0] diff);
        case (diff)
            2'd1:    show_time = TIMER_W'(T_MEDIUM - 1);
            2'd2:    show_time = TIMER_W'(T_HARD - 1);
            default: show_time = TIMER_W'(T_EASY - 1);
        endcase
    endfunction

    always_comb begin
        exp_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (entry_count_q == 4'(i)) begin
                exp_digit = target_q[4*(DIGITS-1-i) +: 4];
            end
        end
    end

    assign entry_shifted = (entry_q << 4) | W'(key_value);
    assign key_is_digit  = (key_value <= 4'd9);
    assign key_accepted  = key_pulse && (key_is_digit || key_value == KEY_CLR);

`ifdef INPUT_TIMEOUT_EN
    logic [31:0] to_q, to_d;

    always_comb begin
        to_d = to_q;
        if (to_load) begin
            to_d = 32'(INPUT_TIMEOUT - 1);
        end else if (to_tick && to_q != 32'd0) begin
            to_d = to_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q <= 32'd0;
        end else begin
            to_q <= to_d;
        end
    end

    assign timeout_hit = (state_q == ST_INPUT) && (to_q == 32'd0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        difficulty_d  = difficulty_q;
        target_d      = target_q;
        entry_d       = entry_q;
        entry_count_d = entry_count_q;
        score_d       = score_q;
        lives_left_d  = lives_left_q;
        timer_d       = timer_q;
        show_number_d = show_number_q;
        seq_req_d     = 1'b0;
        round_ok_d    = 1'b0;
        round_fail_d  = 1'b0;
        to_load       = 1'b0;
        to_tick       = 1'b0;
        miss          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_pulse) begin
                    case (key_value)
                        4'h1: difficulty_d = 2'd0;
                        4'h2: difficulty_d = 2'd1;
                        4'h3: difficulty_d = 2'd2;
                        KEY_START: begin
                            target_d      = seq_in;
                            seq_req_d     = 1'b1;
                            score_d       = '0;
                            lives_left_d  = 3'(LIVES);
                            entry_d       = '0;
                            entry_count_d = 4'd0;
                            timer_d       = show_time(difficulty_q);
                            show_number_d = 1'b1;
                            state_d       = ST_SHOW;
                        end
                        default: ;
                    endcase
                end
            end

            ST_SHOW: begin
                if (timer_q == '0) begin
                    show_number_d = 1'b0;
                    to_load       = 1'b1;
                    state_d       = ST_INPUT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_INPUT: begin
                if (key_accepted) begin
                    to_load = 1'b1;
                    if (key_value == KEY_CLR) begin
                        entry_d       = '0;
                        entry_count_d = 4'd0;
                    end else if (key_value != exp_digit) begin
                        miss = 1'b1;
                    end else if (entry_count_q == 4'(DIGITS - 1)) begin
                        round_ok_d    = 1'b1;
                        if (score_q < SCORE_W'(SCORE_MAX)) begin
                            score_d = score_q + 1'b1;
                        end
                        target_d      = seq_in;
                        seq_req_d     = 1'b1;
                        entry_d       = '0;
                        entry_count_d = 4'd0;
                        timer_d       = show_time(difficulty_q);
                        show_number_d = 1'b1;
                        state_d       = ST_SHOW;
                    end else begin
                        entry_d       = entry_shifted;
                        entry_count_d = entry_count_q + 4'd1;
                    end
                end else if (timeout_hit) begin
                    miss = 1'b1;
                end else begin
                    to_tick = 1'b1;
                end

                // A miss on the last life ends the game; otherwise replay the same target.
                if (miss) begin
                    round_fail_d  = 1'b1;
                    lives_left_d  = lives_left_q - 3'd1;
                    entry_d       = '0;
                    entry_count_d = 4'd0;
                    if (lives_left_q <= 3'd1) begin
                        lives_left_d  = 3'd0;
                        show_number_d = 1'b0;
                        state_d       = ST_OVER;
                    end else begin
                        timer_d       = show_time(difficulty_q);
                        show_number_d = 1'b1;
                        state_d       = ST_SHOW;
                    end
                end
            end

            ST_OVER: begin
                if (key_pulse && key_value == KEY_START) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                show_number_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            difficulty_q  <= 2'd0;
            target_q      <= '0;
            entry_q       <= '0;
            entry_count_q <= 4'd0;
            score_q       <= '0;
            lives_left_q  <= 3'(LIVES);
            timer_q       <= '0;
            show_number_q <= 1'b0;
            seq_req_q     <= 1'b0;
            round_ok_q    <= 1'b0;
            round_fail_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            difficulty_q  <= difficulty_d;
            target_q      <= target_d;
            entry_q       <= entry_d;
            entry_count_q <= entry_count_d;
            score_q       <= score_d;
            lives_left_q  <= lives_left_d;
            timer_q       <= timer_d;
            show_number_q <= show_number_d;
            seq_req_q     <= seq_req_d;
            round_ok_q    <= round_ok_d;
            round_fail_q  <= round_fail_d;
        end
    end

    assign state       = state_q;
    assign difficulty  = difficulty_q;
    assign target      = target_q;
    assign entry       = entry_q;
    assign entry_count = entry_count_q;
    assign score       = score_q;
    assign lives_left  = lives_left_q;
    assign show_number = show_number_q;
    assign seq_req     = seq_req_q;
    assign round_ok    = round_ok_q;
    assign round_fail  = round_fail_q;

endmodule

// File: tb/tb_memory_game_core.sv
// Table-driven directed bench for memory_game_core with short display times,
// LIVES=3 and SCORE_MAX=2 so saturation and game-over are reached quickly.
module tb_memory_game_core;

    logic        clk;
    logic        rst;
    logic        key_pulse;
    logic [3:0]  key_value;
    logic [15:0] seq_in;
    logic        seq_req;
    logic        show_number;
    logic [15:0] target;
    logic [15:0] entry;
    logic [3:0]  entry_count;
    logic [13:0] score;
    logic [2:0]  lives_left;
    logic [1:0]  difficulty;
    logic [1:0]  state;
    logic        round_ok;
    logic        round_fail;

    int n_checks = 0;
    int n_fail   = 0;

    memory_game_core #(
        .DIGITS(4), .TIMER_W(24), .T_EASY(6), .T_MEDIUM(10), .T_HARD(4),
        .LIVES(3), .SCORE_W(14), .SCORE_MAX(2), .INPUT_TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .key_value(key_value),
        .seq_in(seq_in), .seq_req(seq_req), .show_number(show_number),
        .target(target), .entry(entry), .entry_count(entry_count),
        .score(score), .lives_left(lives_left), .difficulty(difficulty),
        .state(state), .round_ok(round_ok), .round_fail(round_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] seq;
        logic [1:0]  st;
        logic [1:0]  diff;
        logic [15:0] tgt;
        logic [15:0] ent;
        logic [3:0]  cnt;
        logic [13:0] scr;
        logic [2:0]  lv;
        logic        ok;
        logic        fl;
        logic        rq;
        int          show_len;
    } vec_t;

    function automatic vec_t mk(logic [3:0] key, logic [15:0] seq, logic [1:0] st,
                                logic [1:0] diff, logic [15:0] tgt, logic [15:0] ent,
                                logic [3:0] cnt, logic [13:0] scr, logic [2:0] lv,
                                logic ok, logic fl, logic rq, int show_len);
        vec_t v;
        v.key = key; v.seq = seq; v.st = st; v.diff = diff; v.tgt = tgt;
        v.ent = ent; v.cnt = cnt; v.scr = scr; v.lv = lv; v.ok = ok;
        v.fl = fl; v.rq = rq; v.show_len = show_len;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input logic [15:0] s);
        @(negedge clk);
        key_pulse = 1'b1;
        key_value = k;
        seq_in    = s;
        @(negedge clk);
        key_pulse = 1'b0;
    endtask

    // Counts display cycles from the current sample point, then expects INPUT.
    task automatic measure_show(input string name, input int exp_len);
        int n;
        n = 0;
        while (show_number === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_show_len"}, n, exp_len);
        chk({name, "_to_input"}, 32'(state), 32'd2);
    endtask

    vec_t vecs[27];

    initial begin
        int   fails_seen;
        int   n;
        logic seen_fail;

        vecs[0]  = mk(4'h2, 16'h1234, 2'd0, 2'd1, 16'h0000, 16'h0000, 4'd0, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[1]  = mk(4'h5, 16'h1234, 2'd0, 2'd1, 16'h0000, 16'h0000, 4'd0, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[2]  = mk(4'hF, 16'h1234, 2'd1, 2'd1, 16'h1234, 16'h0000, 4'd0, 14'd0, 3'd3, 0, 0, 1, 10);
        vecs[3]  = mk(4'h1, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0001, 4'd1, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[4]  = mk(4'hA, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0001, 4'd1, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[5]  = mk(4'h2, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0012, 4'd2, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[6]  = mk(4'hE, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0000, 4'd0, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[7]  = mk(4'h1, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0001, 4'd1, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[8]  = mk(4'h2, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0012, 4'd2, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[9]  = mk(4'h3, 16'h5678, 2'd2, 2'd1, 16'h1234, 16'h0123, 4'd3, 14'd0, 3'd3, 0, 0, 0, 0);
        vecs[10] = mk(4'h4, 16'h5678, 2'd1, 2'd1, 16'h5678, 16'h0000, 4'd0, 14'd1, 3'd3, 1, 0, 1, 10);
        vecs[11] = mk(4'h5, 16'h4321, 2'd2, 2'd1, 16'h5678, 16'h0005, 4'd1, 14'd1, 3'd3, 0, 0, 0, 0);
        vecs[12] = mk(4'h9, 16'h4321, 2'd1, 2'd1, 16'h5678, 16'h0000, 4'd0, 14'd1, 3'd2, 0, 1, 0, 10);
        vecs[13] = mk(4'h5, 16'h4321, 2'd2, 2'd1, 16'h5678, 16'h0005, 4'd1, 14'd1, 3'd2, 0, 0, 0, 0);
        vecs[14] = mk(4'h6, 16'h4321, 2'd2, 2'd1, 16'h5678, 16'h0056, 4'd2, 14'd1, 3'd2, 0, 0, 0, 0);
        vecs[15] = mk(4'h7, 16'h4321, 2'd2, 2'd1, 16'h5678, 16'h0567, 4'd3, 14'd1, 3'd2, 0, 0, 0, 0);
        vecs[16] = mk(4'h8, 16'h4321, 2'd1, 2'd1, 16'h4321, 16'h0000, 4'd0, 14'd2, 3'd2, 1, 0, 1, 10);
        vecs[17] = mk(4'h4, 16'h1111, 2'd2, 2'd1, 16'h4321, 16'h0004, 4'd1, 14'd2, 3'd2, 0, 0, 0, 0);
        vecs[18] = mk(4'h3, 16'h1111, 2'd2, 2'd1, 16'h4321, 16'h0043, 4'd2, 14'd2, 3'd2, 0, 0, 0, 0);
        vecs[19] = mk(4'h2, 16'h1111, 2'd2, 2'd1, 16'h4321, 16'h0432, 4'd3, 14'd2, 3'd2, 0, 0, 0, 0);
        vecs[20] = mk(4'h1, 16'h1111, 2'd1, 2'd1, 16'h1111, 16'h0000, 4'd0, 14'd2, 3'd2, 1, 0, 1, 10);
        vecs[21] = mk(4'h0, 16'h2222, 2'd1, 2'd1, 16'h1111, 16'h0000, 4'd0, 14'd2, 3'd1, 0, 1, 0, 10);
        vecs[22] = mk(4'h2, 16'h2222, 2'd3, 2'd1, 16'h1111, 16'h0000, 4'd0, 14'd2, 3'd0, 0, 1, 0, 0);
        vecs[23] = mk(4'h1, 16'h2222, 2'd3, 2'd1, 16'h1111, 16'h0000, 4'd0, 14'd2, 3'd0, 0, 0, 0, 0);
        vecs[24] = mk(4'hF, 16'h2222, 2'd0, 2'd1, 16'h1111, 16'h0000, 4'd0, 14'd2, 3'd0, 0, 0, 0, 0);
        vecs[25] = mk(4'h3, 16'h2222, 2'd0, 2'd2, 16'h1111, 16'h0000, 4'd0, 14'd2, 3'd0, 0, 0, 0, 0);
        vecs[26] = mk(4'hF, 16'h2222, 2'd1, 2'd2, 16'h2222, 16'h0000, 4'd0, 14'd0, 3'd3, 0, 0, 1, 4);

        rst       = 1'b0;
        key_pulse = 1'b0;
        key_value = 4'h0;
        seq_in    = 16'h0000;
        repeat (3) @(negedge clk);

        chk("rst_state",  32'(state), 32'd0);
        chk("rst_diff",   32'(difficulty), 32'd0);
        chk("rst_score",  32'(score), 32'd0);
        chk("rst_target", 32'(target), 32'd0);
        chk("rst_entry",  32'(entry), 32'd0);
        chk("rst_count",  32'(entry_count), 32'd0);
        chk("rst_lives",  32'(lives_left), 32'd3);
        chk("rst_show",   32'(show_number), 32'd0);
        chk("rst_pulses", {29'd0, seq_req, round_ok, round_fail}, 32'd0);

        rst = 1'b1;

        for (int i = 0; i < 27; i++) begin
            press(vecs[i].key, vecs[i].seq);
            chk($sformatf("v%0d_state", i),  32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_diff", i),   32'(difficulty), 32'(vecs[i].diff));
            chk($sformatf("v%0d_target", i), 32'(target), 32'(vecs[i].tgt));
            chk($sformatf("v%0d_entry", i),  32'(entry), 32'(vecs[i].ent));
            chk($sformatf("v%0d_count", i),  32'(entry_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_score", i),  32'(score), 32'(vecs[i].scr));
            chk($sformatf("v%0d_lives", i),  32'(lives_left), 32'(vecs[i].lv));
            chk($sformatf("v%0d_ok", i),     32'(round_ok), 32'(vecs[i].ok));
            chk($sformatf("v%0d_fail", i),   32'(round_fail), 32'(vecs[i].fl));
            chk($sformatf("v%0d_seqreq", i), 32'(seq_req), 32'(vecs[i].rq));
            chk($sformatf("v%0d_show", i),   32'(show_number), 32'(vecs[i].st == 2'd1));
            if (vecs[i].show_len != 0) begin
                measure_show($sformatf("v%0d", i), vecs[i].show_len);
            end
        end

        // Miss on HARD, then a key during the replay must be ignored.
        press(4'h9, 16'h3333);
        chk("hard_miss_fail",  32'(round_fail), 32'd1);
        chk("hard_miss_lives", 32'(lives_left), 32'd2);
        chk("hard_miss_state", 32'(state), 32'd1);
        chk("hard_miss_seqrq", 32'(seq_req), 32'd0);
        press(4'h2, 16'h3333);
        chk("show_key_state",  32'(state), 32'd1);
        chk("show_key_count",  32'(entry_count), 32'd0);
        chk("show_key_entry",  32'(entry), 32'd0);
        chk("show_key_target", 32'(target), 32'h2222);
        n = 0;
        while (state !== 2'd2 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("replay_reach_input", 32'(state), 32'd2);

`ifdef INPUT_TIMEOUT_EN
        n = 0;
        seen_fail = 1'b0;
        while (!seen_fail && n < 200) begin
            @(negedge clk);
            n++;
            seen_fail = round_fail;
        end
        chk("timeout_cycles", 32'(n), 32'd20);
        chk("timeout_lives",  32'(lives_left), 32'd1);
        chk("timeout_state",  32'(state), 32'd1);
`else
        fails_seen = 0;
        seen_fail  = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (round_fail) begin
                fails_seen++;
                seen_fail = 1'b1;
            end
        end
        chk("no_timeout_fails", 32'(fails_seen), 32'd0);
        chk("no_timeout_state", 32'(state), 32'd2);
        chk("no_timeout_lives", 32'(lives_left), 32'd2);
        n = 0;
`endif

        // Asynchronous reset mid-round.
        #2 rst = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_lives", 32'(lives_left), 32'd3);
        chk("arst_target", 32'(target), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
